trace_window_ctrl: RTL and testbench

TRACE_WINDOW_CTRL -- requirements
Module: trace_window_ctrl

---
 rtl/trace_window_ctrl.sv | 151 +++++++++++++++
 tb/tb_trace_window_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/trace_window_ctrl.sv
// Trace capture window: arms on host request, captures tracer records after a trigger fetch, buffers them and drains them to a sink.
// Optional per-record trigger-relative timestamps (out_cycle) when TRACE_WINDOW_TIMESTAMP_EN is defined.
package trace_window_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } trace_format;
endpackage

module trace_window_ctrl
    import trace_window_pkg::*;
#(
    parameter int INSTR_ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH       = 8,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arm,
    input  logic                        disarm,
    input  logic [INSTR_ADDR_WIDTH-1:0] trig_addr,
    input  logic [LEN_WIDTH-1:0]        capture_len,
    input  logic                        instr_req,
    input  logic                        instr_gnt,
    input  logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
    input  logic                        trace_valid,
    input  trace_format                 trace_data,
    input  logic                        tracer_lock,
    output logic                        out_valid,
    input  logic                        out_ready,
    output trace_format                 out_data,
    output logic [1:0]                  state_o,
    output logic [LEN_WIDTH-1:0]        captured_count,
    output logic                        overflow,
    output logic                        done
`ifdef TRACE_WINDOW_TIMESTAMP_EN
    ,
    output logic [31:0]                 out_cycle
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t state, state_nxt;

    trace_format    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    fill;
    logic           empty, full, pop, push, drop, trigger, limit_hit, session_start;
    logic [LEN_WIDTH-1:0] cnt_inc;

    assign empty     = (fill == '0);
    assign full      = (fill == (AW+1)'(FIFO_DEPTH));
    assign out_valid = ((state == CAPTURE) || (state == DRAIN)) && !empty;
    assign pop       = out_valid && out_ready;
    assign trigger   = instr_req && instr_gnt && (instr_addr == trig_addr);
    assign limit_hit = (capture_len != '0) && (captured_count >= capture_len);
    // A full FIFO still accepts a record when a pop frees a slot in the same cycle.
    assign push      = (state == CAPTURE) && trace_valid && !limit_hit && (!full || pop);
    assign drop      = (state == CAPTURE) && trace_valid && !limit_hit && full && !pop;
    assign cnt_inc   = (&captured_count) ? captured_count : captured_count + 1'b1;
    assign session_start = (state == IDLE) && arm;
    assign state_o   = state;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:    if (arm) state_nxt = ARMED;
            ARMED: begin
                if (disarm)       state_nxt = DRAIN;
                else if (trigger) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (disarm || tracer_lock ||
                    (push && (capture_len != '0) && (cnt_inc == capture_len)))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (empty) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill           <= '0;
            captured_count <= '0;
            overflow       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (session_start) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                fill           <= '0;
                captured_count <= '0;
                overflow       <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr         <= wr_ptr + 1'b1;
                    captured_count <= cnt_inc;
                end
                if (pop)  rd_ptr   <= rd_ptr + 1'b1;
                if (drop) overflow <= 1'b1;
                case ({push, pop})
                    2'b10:   fill <= fill + 1'b1;
                    2'b01:   fill <= fill - 1'b1;
                    default: fill <= fill;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= trace_data;
    end

`ifdef TRACE_WINDOW_TIMESTAMP_EN
    logic [31:0] ts_ctr;
    logic [31:0] ts_mem [FIFO_DEPTH];

    // Trigger cycle is cycle 0, so the first CAPTURE cycle sees 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          ts_ctr <= '0;
        else if ((state == ARMED) && (state_nxt == CAPTURE)) ts_ctr <= 32'd1;
        else if (state == CAPTURE)                        ts_ctr <= ts_ctr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) ts_mem[wr_ptr] <= ts_ctr;
    end

    assign out_cycle = out_valid ? ts_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_trace_window_ctrl.sv
// Scoreboard bench for trace_window_ctrl: directed sessions plus random traffic against a queue-based session model.
module tb_trace_window_ctrl;
    import trace_window_pkg::*;

    localparam int AWID  = 16;
    localparam int DEPTH = 8;
    localparam int LW    = 4;
    localparam int MAXC  = (1 << LW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            arm = 1'b0, disarm = 1'b0;
    logic [AWID-1:0] trig_addr = '0, instr_addr = '0;
    logic [LW-1:0]   capture_len = '0;
    logic            instr_req = 1'b0, instr_gnt = 1'b0;
    logic            trace_valid = 1'b0, tracer_lock = 1'b0, out_ready = 1'b0;
    trace_format     trace_data = '0;
    logic            out_valid, overflow, done;
    trace_format     out_data;
    logic [1:0]      state_o;
    logic [LW-1:0]   captured_count;
`ifdef TRACE_WINDOW_TIMESTAMP_EN
    logic [31:0]     out_cycle;
`endif

    trace_window_ctrl #(.INSTR_ADDR_WIDTH(AWID), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .trig_addr(trig_addr),
        .capture_len(capture_len), .instr_req(instr_req), .instr_gnt(instr_gnt),
        .instr_addr(instr_addr), .trace_valid(trace_valid), .trace_data(trace_data),
        .tracer_lock(tracer_lock), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .state_o(state_o), .captured_count(captured_count),
        .overflow(overflow), .done(done)
`ifdef TRACE_WINDOW_TIMESTAMP_EN
        , .out_cycle(out_cycle)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Session model: 0 idle, 1 armed, 2 capturing, 3 draining.
    int          m_st = 0, m_occ = 0, m_cnt = 0, m_ovf = 0;
    trace_format exp_q[$];
    int unsigned m_ts = 0;
    int unsigned exp_ts[$];

    always @(negedge clk) begin
        int ev, ed, pop, occ_after, pushed;
        if (rst) begin
            m_st = 0; m_occ = 0; m_cnt = 0; m_ovf = 0; m_ts = 0;
            exp_q.delete();
            exp_ts.delete();
            chk("rst_state", state_o, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_count", captured_count, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_done", done, 0);
        end else begin
            ev = ((m_st == 2 || m_st == 3) && m_occ > 0) ? 1 : 0;
            ed = (m_st == 3 && m_occ == 0) ? 1 : 0;
            chk("state", state_o, m_st);
            chk("out_valid", out_valid, ev);
            chk("count", captured_count, m_cnt);
            chk("overflow", overflow, m_ovf);
            chk("done", done, ed);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL out_data: unexpected record %0h, none expected", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
`ifdef TRACE_WINDOW_TIMESTAMP_EN
                    if (exp_ts.size() > 0) chk("out_cycle", out_cycle, exp_ts.pop_front());
`endif
                end
            end
            pop       = (ev != 0 && out_ready) ? 1 : 0;
            occ_after = m_occ - pop;
            pushed    = 0;
            case (m_st)
                0: if (arm) begin m_st = 1; m_cnt = 0; m_ovf = 0; end
                1: begin
                    if (disarm) m_st = 3;
                    else if (instr_req && instr_gnt && instr_addr == trig_addr) begin
                        m_st = 2; m_ts = 1;
                    end
                end
                2: begin
                    if (trace_valid && (capture_len == 0 || m_cnt < capture_len)) begin
                        if (occ_after < DEPTH) begin
                            pushed = 1;
                            exp_q.push_back(trace_data);
                            exp_ts.push_back(m_ts);
                            m_cnt = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
                        end else m_ovf = 1;
                    end
                    if (disarm || tracer_lock || (pushed != 0 && capture_len != 0 && m_cnt == capture_len))
                        m_st = 3;
                    m_ts++;
                end
                default: if (m_occ == 0) m_st = 0;
            endcase
            m_occ = occ_after + pushed;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        arm = 0; disarm = 0; instr_req = 0; instr_gnt = 0;
        trace_valid = 0; tracer_lock = 0;
        trace_data = {$urandom, $urandom};
    endtask

    task automatic start(input logic [LW-1:0] len, input logic [AWID-1:0] ta);
        arm = 1; capture_len = len; trig_addr = ta;
        tick();
        instr_req = 1; instr_gnt = 1; instr_addr = ta;
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        tick();

        // Length-limited capture: 5 strobes, only 3 taken.
        out_ready = 1;
        start(3, 16'h0100);
        repeat (5) begin trace_valid = 1; tick(); end
        repeat (6) tick();

        // Overflow with a stalled sink, then drain in order.
        out_ready = 0;
        start(0, 16'h0200);
        repeat (10) begin trace_valid = 1; tick(); end
        disarm = 1; tick();
        repeat (3) tick();
        out_ready = 1;
        repeat (12) tick();

        // Tracer lock ends the window.
        start(0, 16'h0300);
        repeat (4) begin trace_valid = 1; tick(); end
        tracer_lock = 1; tick();
        repeat (8) tick();

        // Disarm beats a same-cycle trigger.
        arm = 1; capture_len = 2; trig_addr = 16'h0400; tick();
        disarm = 1; instr_req = 1; instr_gnt = 1; instr_addr = 16'h0400; tick();
        repeat (4) tick();

        // Count saturation with unbounded capture.
        start(0, 16'h0500);
        repeat (20) begin trace_valid = 1; tick(); end
        disarm = 1; tick();
        repeat (4) tick();

        // Reset with buffered records mid-capture.
        out_ready = 0;
        start(0, 16'h0600);
        repeat (3) begin trace_valid = 1; tick(); end
        rst = 1;
        tick();
        rst = 0;
        out_ready = 1;
        repeat (4) tick();

        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom % 600 == 0);
            if ($urandom % 15 == 0) begin
                arm = 1;
                capture_len = LW'($urandom % 7);
                trig_addr = AWID'($urandom % 4);
            end
            disarm      = ($urandom % 60 == 0);
            tracer_lock = ($urandom % 70 == 0);
            instr_req   = $urandom % 2;
            instr_gnt   = $urandom % 2;
            instr_addr  = AWID'($urandom % 6);
            trace_valid = $urandom % 2;
            out_ready   = ((i / 200) % 2 == 0) ? ($urandom % 5 != 0) : ($urandom % 4 == 0);
        end
        rst = 0;
        out_ready = 1;
        repeat (20) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
